// File: rtl/cpu_pkg.sv
// Shared cpu-side definitions: reset vector, bus widths and the memory
// bridge state encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hb0000000;
  localparam int          WORD_W       = 32;
  localparam int          BYTE_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the memory read latency; zero_o flags the
// edge on which the count reaches zero so the byte can be captured there.
module mem_lat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridges one aligned 32-bit cpu access onto four byte cycles of the external
// byte-wide SRAM/ROM bus; reads assemble little-endian, writes honour byte enables.
module cpu_mem_bridge
  import cpu_pkg::*;
#(
  parameter int          ADDR_W  = 16,
  parameter logic [31:0] BASE    = RESET_VECTOR,
  parameter int          MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [WORD_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [3:0]        i_be,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_ack,
  output logic              o_err,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [BYTE_W-1:0] o_mem_wdata,
  output logic              o_mem_re,
  output logic              o_mem_we,
  input  logic [BYTE_W-1:0] i_mem_rdata
);

  bridge_state_e     state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic [WORD_W-1:0] req_off;
  logic              req_bad;
  logic              cnt_load, cnt_dec, cnt_zero;

  // Unsigned wrap makes addresses below BASE land far outside the window.
  assign req_off = i_addr - BASE;
  assign req_bad = ((req_off >> ADDR_W) != '0) || (i_addr[1:0] != 2'b00);

  mem_lat_counter #(.CNT_W(3)) u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (3'(MEM_LAT)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    we_d        = we_q;
    err_d       = err_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    o_mem_re    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_ack       = 1'b0;
    o_err       = 1'b0;
    o_rdata     = '0;
    o_busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          wdata_d = i_wdata;
          be_d    = i_be;
          off_d   = req_off[ADDR_W-1:0];
          err_d   = req_bad;
          rdata_d = '0;
          k_d     = 2'd0;
          state_d = req_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        o_mem_addr = off_q + ADDR_W'(k_q);
        if (we_q) begin
          o_mem_we    = be_q[k_q];
          o_mem_wdata = wdata_q[{k_q, 3'b000} +: BYTE_W];
          if (k_q == 2'd3) begin
            state_d = RESP;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else begin
          o_mem_re = 1'b1;
          cnt_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          rdata_d[{k_q, 3'b000} +: BYTE_W] = i_mem_rdata;
          if (k_q == 2'd3) begin
            state_d = RESP;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = ISSUE;
          end
        end
      end
      RESP: begin
        o_ack   = 1'b1;
        o_err   = err_q;
        o_rdata = (we_q || err_q) ? '0 : rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      we_q    <= we_d;
      err_q   <= err_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: two instances (read latency 1 and 3) on a shared
// byte memory, checked against a transaction-level reference model.
module tb_cpu_mem_bridge;

  localparam logic [31:0] BASE  = 32'hb0000000;
  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // instance A signals
  logic        reset_a = 1'b1, req_a = 1'b0, we_a = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic [3:0]  be_a = '0;
  logic [31:0] rdata_a;
  logic        ack_a, err_a, busy_a, mre_a, mwe_a;
  logic [15:0] maddr_a;
  logic [7:0]  mwdata_a, mrdata_a;

  // instance B signals
  logic        reset_b = 1'b1, req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic [3:0]  be_b = '0;
  logic [31:0] rdata_b;
  logic        ack_b, err_b, busy_b, mre_b, mwe_b;
  logic [15:0] maddr_b;
  logic [7:0]  mwdata_b, mrdata_b;

  cpu_mem_bridge #(.ADDR_W(16), .BASE(BASE), .MEM_LAT(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset_a), .i_req(req_a), .i_we(we_a), .i_addr(addr_a),
    .i_wdata(wdata_a), .i_be(be_a), .o_rdata(rdata_a), .o_ack(ack_a), .o_err(err_a),
    .o_busy(busy_a), .o_mem_addr(maddr_a), .o_mem_wdata(mwdata_a), .o_mem_re(mre_a),
    .o_mem_we(mwe_a), .i_mem_rdata(mrdata_a)
  );

  cpu_mem_bridge #(.ADDR_W(16), .BASE(BASE), .MEM_LAT(LAT_B)) u_dut_b (
    .clk(clk), .reset(reset_b), .i_req(req_b), .i_we(we_b), .i_addr(addr_b),
    .i_wdata(wdata_b), .i_be(be_b), .o_rdata(rdata_b), .o_ack(ack_b), .o_err(err_b),
    .o_busy(busy_b), .o_mem_addr(maddr_b), .o_mem_wdata(mwdata_b), .o_mem_re(mre_b),
    .o_mem_we(mwe_b), .i_mem_rdata(mrdata_b)
  );

  // memory seen by the DUTs, and the model's own copy
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic       mem_init = 1'b0;
  logic [7:0] pipe_a [LAT_A];
  logic [7:0] pipe_b [LAT_B];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
    end else begin
      if (mwe_a) mem[maddr_a] <= mwdata_a;
      if (mwe_b) mem[maddr_b] <= mwdata_b;
    end
  end

  // read data is valid exactly LAT clocks after the strobe; garbage otherwise
  always @(posedge clk) begin
    pipe_a[0] <= mre_a ? mem[maddr_a] : 8'($urandom);
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= mre_b ? mem[maddr_b] : 8'($urandom);
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign mrdata_a = pipe_a[LAT_A-1];
  assign mrdata_b = pipe_b[LAT_B-1];

  // bus monitor: strobe log {kind, addr, data} plus rule violation counters
  logic [31:0] log_a[$], log_b[$], exp_q[$];
  int both_a = 0, both_b = 0, idle_out_a = 0, idle_out_b = 0, ack_cnt_a = 0;

  always @(negedge clk) begin
    if (mre_a) log_a.push_back({8'h00, maddr_a, 8'h00});
    if (mwe_a) log_a.push_back({8'h01, maddr_a, mwdata_a});
    if (mre_b) log_b.push_back({8'h00, maddr_b, 8'h00});
    if (mwe_b) log_b.push_back({8'h01, maddr_b, mwdata_b});
    if (mre_a && mwe_a) both_a++;
    if (mre_b && mwe_b) both_b++;
    if (!busy_a && (mre_a || mwe_a || maddr_a != 0 || mwdata_a != 0)) idle_out_a++;
    if (!busy_b && (mre_b || mwe_b || maddr_b != 0 || mwdata_b != 0)) idle_out_b++;
    if (ack_a) ack_cnt_a++;
  end

  // reference model: outcome of one whole transaction
  logic        exp_err;
  int          exp_lat;
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata_a;

  task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int lat);
    logic [31:0] off;
    logic [15:0] a16;
    off = addr - BASE;
    exp_q.delete();
    exp_rdata = '0;
    exp_err   = (off >= 32'h0001_0000) || (addr % 4 != 0);
    if (exp_err) begin
      exp_lat = 1;
    end else if (we) begin
      exp_lat = 5;
      for (int k = 0; k < 4; k++) begin
        a16 = off[15:0] + 16'(k);
        if (be[k]) begin
          exp_q.push_back({8'h01, a16, wd[8*k +: 8]});
          ref_mem[a16] = wd[8*k +: 8];
        end
      end
    end else begin
      exp_lat = 4 * (lat + 1) + 1;
      for (int k = 0; k < 4; k++) begin
        a16 = off[15:0] + 16'(k);
        exp_q.push_back({8'h00, a16, 8'h00});
        exp_rdata[8*k +: 8] = ref_mem[a16];
      end
    end
  endtask

  task automatic txn_a(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    int n;
    bit seen;
    predict(we, addr, wd, be, LAT_A);
    @(negedge clk);
    log_a.delete();
    req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; be_a = be;
    @(posedge clk);
    #1;
    // scramble inputs after acceptance; a stray req while busy must be ignored
    req_a = 1'($urandom); we_a = 1'($urandom); addr_a = $urandom;
    wdata_a = $urandom; be_a = 4'($urandom);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_busy"}, 32'(busy_a), 32'd1);
      if (ack_a) seen = 1'b1;
    end
    req_a = 1'b0;
    last_rdata_a = rdata_a;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_err"}, 32'(err_a), 32'(exp_err));
    chk({tag, "_rdata"}, rdata_a, exp_rdata);
    @(negedge clk);
    chk({tag, "_ackpulse"}, {30'd0, busy_a, ack_a}, 32'd0);
    chk({tag, "_nstrobe"}, log_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_a.size(); i++)
      chk({tag, "_strobe"}, log_a[i], exp_q[i]);
  endtask

  initial begin
    int n, acks0, sel;
    bit seen;
    logic [31:0] a, exp1, exp2;

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
    ref_mem[0] = 8'h78; ref_mem[1] = 8'h56; ref_mem[2] = 8'h34; ref_mem[3] = 8'h12;
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;

    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_ctl", {27'd0, ack_a, err_a, busy_a, mre_a, mwe_a}, 32'd0);
    chk("rst_mem", {8'd0, maddr_a, mwdata_a}, 32'd0);
    chk("rst_ctl_b", {27'd0, ack_b, err_b, busy_b, mre_b, mwe_b}, 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;

    txn_a("rd0", 1'b0, BASE, 32'h0, 4'h0);
    chk("rd0_word", last_rdata_a, 32'h12345678);
    txn_a("wr4", 1'b1, BASE + 32'd4, 32'hcafebabe, 4'b0101);
    chk("wr4_byte0", log_a.size() > 0 ? log_a[0] : 32'hffffffff, {8'h01, 16'h0004, 8'hbe});
    chk("wr4_byte2", log_a.size() > 1 ? log_a[1] : 32'hffffffff, {8'h01, 16'h0006, 8'hfe});
    txn_a("oow", 1'b0, 32'h00000010, 32'h0, 4'h0);
    txn_a("misal", 1'b1, BASE + 32'd2, 32'h11223344, 4'hf);
    txn_a("top", 1'b0, BASE + 32'h0000fffc, 32'h0, 4'h0);
    txn_a("past_top", 1'b0, BASE + 32'h00010000, 32'h0, 4'h0);
    txn_a("below", 1'b1, BASE - 32'd4, 32'h55aa55aa, 4'hf);

    // reset asserted during the byte-2 wait of a read
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; addr_a = BASE;
    @(posedge clk);
    #1 req_a = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstmid_busy_before", 32'(busy_a), 32'd1);
    acks0 = ack_cnt_a;
    #2 reset_a = 1'b1;
    #1;
    chk("rstmid_drop", {28'd0, busy_a, mre_a, mwe_a, ack_a}, 32'd0);
    repeat (2) @(negedge clk);
    reset_a = 1'b0;
    repeat (12) @(negedge clk);
    chk("rstmid_noack", ack_cnt_a, acks0);
    txn_a("rd_after_rst", 1'b0, BASE, 32'h0, 4'h0);
    chk("rd_after_rst_word", last_rdata_a, 32'h12345678);

    // latency 3, back-to-back reads with req held high
    predict(1'b0, BASE, 32'h0, 4'h0, LAT_B);
    exp1 = exp_rdata;
    predict(1'b0, BASE + 32'd4, 32'h0, 4'h0, LAT_B);
    exp2 = exp_rdata;
    @(negedge clk);
    log_b.delete();
    req_b = 1'b1; we_b = 1'b0; addr_b = BASE;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (ack_b) seen = 1'b1;
    end
    chk("b2b_lat1", n, 17);
    chk("b2b_rdata1", rdata_b, exp1);
    addr_b = BASE + 32'd4;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (ack_b) seen = 1'b1;
    end
    req_b = 1'b0;
    chk("b2b_lat2", n, 18);
    chk("b2b_rdata2", rdata_b, exp2);
    chk("b2b_err2", 32'(err_b), 32'd0);
    chk("b2b_nstrobe", log_b.size(), 8);
    for (int i = 0; i < 8 && i < log_b.size(); i++)
      chk("b2b_strobe", log_b[i], {8'h00, 16'(i), 8'h00});

    // randomized traffic on the latency-1 instance
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: a = $urandom;
        1: a = BASE + {14'd0, 16'($urandom_range(0, 16383)), 2'b00} + 32'($urandom_range(1, 3));
        2: a = BASE + 32'h00010000 + 32'(4 * $urandom_range(0, 15));
        3: a = BASE + 32'h0000fffc;
        default: a = BASE + 32'(4 * $urandom_range(0, 16383));
      endcase
      if (t % 5 == 4) a = BASE + 32'(4 * $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn_a("rnd", 1'($urandom), a, $urandom, 4'($urandom));
    end

    chk("re_we_overlap_a", both_a, 0);
    chk("re_we_overlap_b", both_b, 0);
    chk("idle_outputs_a", idle_out_a, 0);
    chk("idle_outputs_b", idle_out_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
